// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port unified memory between instruction fetch (IF)
//           and data access (DM); DM wins conflicts unless IF has lost STARVE_MAX
//           conflicts in a row, in which case IF is forced through.
// Latency : grant at t (combinational) -> mem_en_o at t+1 -> rvalid at t+1+MEM_LATENCY;
//           the next grant comes no earlier than t+2+MEM_LATENCY.
// Backpr. : requesters hold req until gnt; requests are only looked at in IDLE,
//           so a busy arbiter simply withholds gnt. stall_f_o freezes fetch/decode.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_req_i/if_addr_i  fetch request and address (held until if_gnt_o)
//   if_gnt_o            fetch grant, combinational, IDLE only
//   if_rvalid_o/if_rdata_o  fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_byte_i/dm_addr_i/dm_wdata_i  data request fields
//   dm_gnt_o            data grant, combinational, IDLE only
//   dm_rvalid_o/dm_rdata_o  data completion pulse; load data, 0 for store ack
//   mem_en_o/mem_we_o/mem_byte_o/mem_addr_o/mem_wdata_o  registered memory command
//   mem_rdata_i         memory read data, valid MEM_LATENCY cycles after mem_en_o
//   stall_f_o           fetch stall = if_req_i && !if_rvalid_o
//   conflict_cnt_o/starve_cnt_o  performance counters, present only when
//                       ARB_PERF_CNT_EN is defined
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic                  dm_byte_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_f_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           conflict_cnt_o,
  output logic [31:0]           starve_cnt_o
`endif
);

  // Latency counter must hold values 0..MEM_LATENCY; starve counter 0..STARVE_MAX.
  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY);
  localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbStateT;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } ownerT;

  arbStateT             state;
  arbStateT             stateNext;
  ownerT                owner;
  logic [CNT_W-1:0]     latCnt;
  logic [STV_W-1:0]     starveCnt;
  logic [DATA_WIDTH-1:0] ifRdataQ;
  logic [DATA_WIDTH-1:0] dmRdataQ;

  logic ifGnt;
  logic dmGnt;
  logic forceIf;
  logic rspFire;

  // ---------------------------------------------------------------------------
  // Next-state / grant logic. Grants are suppressed while rst is high so that a
  // request present during reset never gets through.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    ifGnt     = 1'b0;
    dmGnt     = 1'b0;
    rspFire   = 1'b0;
    forceIf   = (starveCnt == STV_TOP);

    case (state)
      IDLE: begin
        if (!rst) begin
          if (if_req_i && (!dm_req_i || forceIf)) begin
            ifGnt = 1'b1;
          end else if (dm_req_i) begin
            dmGnt = 1'b1;
          end
          if (ifGnt || dmGnt) begin
            stateNext = ISSUE;
          end
        end
      end
      ISSUE: begin
        stateNext = WAIT;
      end
      WAIT: begin
        if (latCnt == LAT_LAST) begin
          // Response is presented in the same cycle the memory data is valid,
          // so rvalid is combinational rather than one cycle late.
          rspFire   = !rst;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign if_gnt_o    = ifGnt;
  assign dm_gnt_o    = dmGnt;
  assign if_rvalid_o = rspFire && (owner == OWN_IF);
  assign dm_rvalid_o = rspFire && (owner == OWN_DM);

  // During the response pulse the live memory data is forwarded; afterwards the
  // captured copy is held until the same requester completes again.
  assign if_rdata_o = if_rvalid_o ? mem_rdata_i : ifRdataQ;
  assign dm_rdata_o = dm_rvalid_o ? (mem_we_o ? '0 : mem_rdata_i) : dmRdataQ;

  assign stall_f_o = if_req_i && !if_rvalid_o;

  // ---------------------------------------------------------------------------
  // State, memory command registers and response capture.
  // mem_* fields stay latched after ISSUE so mem_we_o can still tell a store
  // ack from a load when the response fires.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      latCnt      <= '0;
      starveCnt   <= '0;
      ifRdataQ    <= '0;
      dmRdataQ    <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_byte_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (ifGnt) begin
            owner       <= OWN_IF;
            mem_en_o    <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_byte_o  <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            starveCnt   <= '0;
          end else if (dmGnt) begin
            owner       <= OWN_DM;
            mem_en_o    <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_byte_o  <= dm_byte_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            // Only a conflict that IF lost counts towards starvation.
            if (if_req_i && (starveCnt != STV_TOP)) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          mem_en_o <= 1'b0;
          latCnt   <= CNT_W'(1);
        end
        WAIT: begin
          if (latCnt == LAT_LAST) begin
            latCnt <= '0;
            if (owner == OWN_IF) begin
              ifRdataQ <= mem_rdata_i;
            end else begin
              dmRdataQ <= mem_we_o ? '0 : mem_rdata_i;
            end
          end else begin
            latCnt <= latCnt + 1'b1;
          end
        end
        default: begin
          latCnt <= '0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, free-running and wrapping.
  // ---------------------------------------------------------------------------
  logic [31:0] conflictCnt;
  logic [31:0] forcedCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflictCnt <= '0;
      forcedCnt   <= '0;
    end else begin
      if ((ifGnt || dmGnt) && if_req_i && dm_req_i) begin
        conflictCnt <= conflictCnt + 32'd1;
      end
      if (ifGnt && forceIf) begin
        forcedCnt <= forcedCnt + 32'd1;
      end
    end
  end

  assign conflict_cnt_o = conflictCnt;
  assign starve_cnt_o   = forcedCnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : scoreboard bench for mem_arbiter; directed stimulus pushes expected
//           grants, memory commands and responses, a negedge monitor pops them.
// Latency : expectations carry the exact cycle each event must appear in.
// Backpr. : requesters hold their request until the expected grant cycle.
module tb_mem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [DW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic          dm_byte_i;
  logic [DW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic          mem_byte_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_f_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   conflict_cnt_o;
  logic [31:0]   starve_cnt_o;
`endif

  mem_arbiter #(
    .DATA_WIDTH (DW),
    .MEM_LATENCY(2),
    .STARVE_MAX (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_byte_i  (dm_byte_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_gnt_o   (dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_byte_o (mem_byte_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .stall_f_o  (stall_f_o)
`ifdef ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o(conflict_cnt_o),
    .starve_cnt_o  (starve_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { logic isDm; int cyc; } gntExpT;
  typedef struct { logic we; logic byteAcc; logic [31:0] addr; logic [31:0] wdata; int cyc; } memExpT;
  typedef struct { logic isDm; logic [31:0] data; int cyc; } rspExpT;

  gntExpT gntQ[$];
  memExpT memQ[$];
  rspExpT rspQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen at cycle %0d, expected none", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushAccess(input logic isDm, input logic we, input logic byteAcc,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int t, input logic withRsp);
    gntQ.push_back('{isDm: isDm, cyc: t});
    memQ.push_back('{we: we, byteAcc: byteAcc, addr: addr, wdata: wdata, cyc: t + 1});
    if (withRsp) rspQ.push_back('{isDm: isDm, data: (isDm && we) ? 32'h0 : rdata, cyc: t + 3});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  // ---------------------------------------------------------------------------
  gntExpT gE;
  memExpT mE;
  rspExpT rE;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_gnt", {30'b0, if_gnt_o, dm_gnt_o}, 32'h0);
      check("rst_rvalid", {30'b0, if_rvalid_o, dm_rvalid_o}, 32'h0);
      check("rst_mem_en", {31'b0, mem_en_o}, 32'h0);
    end else begin
      if (if_gnt_o || dm_gnt_o) begin
        if (gntQ.size() == 0) unexpected("unexpected_gnt");
        else begin
          gE = gntQ.pop_front();
          check("gnt_single", {31'b0, if_gnt_o & dm_gnt_o}, 32'h0);
          check("gnt_is_dm", {31'b0, dm_gnt_o}, {31'b0, gE.isDm});
          check("gnt_cycle", cyc, gE.cyc);
        end
      end
      if (mem_en_o) begin
        if (memQ.size() == 0) unexpected("unexpected_mem_en");
        else begin
          mE = memQ.pop_front();
          check("mem_we", {31'b0, mem_we_o}, {31'b0, mE.we});
          check("mem_byte", {31'b0, mem_byte_o}, {31'b0, mE.byteAcc});
          check("mem_addr", mem_addr_o, mE.addr);
          check("mem_wdata", mem_wdata_o, mE.wdata);
          check("mem_cycle", cyc, mE.cyc);
        end
      end
      if (if_rvalid_o || dm_rvalid_o) begin
        if (rspQ.size() == 0) unexpected("unexpected_rvalid");
        else begin
          rE = rspQ.pop_front();
          check("rsp_single", {31'b0, if_rvalid_o & dm_rvalid_o}, 32'h0);
          check("rsp_is_dm", {31'b0, dm_rvalid_o}, {31'b0, rE.isDm});
          check("rsp_data", dm_rvalid_o ? dm_rdata_o : if_rdata_o, rE.data);
          check("rsp_cycle", cyc, rE.cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus.
  // ---------------------------------------------------------------------------
  int t;
  logic [7:0] heldPattern;

  initial begin
    rst = 1'b1;
    if_req_i = 1'b1;  if_addr_i = 32'h80;
    dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_byte_i = 1'b0;
    dm_addr_i = 32'h40;  dm_wdata_i = 32'h0;
    mem_rdata_i = 32'hDEADBEEF;

    // Reset held two cycles with both requests up; DM wins right after release.
    tick();
    tick();
    rst = 1'b0;
    t = cyc;
    pushAccess(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, t, 1'b1);
    tick();
    if_req_i = 1'b0;  dm_req_i = 1'b0;
    repeat (3) tick();

    // Lone fetch at 0x100, with fetch-stall tracking.
    t = cyc;
    if_req_i = 1'b1;  if_addr_i = 32'h100;
    pushAccess(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, t, 1'b1);
    @(negedge clk); check("stall_t0", {31'b0, stall_f_o}, 32'h1);
    tick(); @(negedge clk); check("stall_t1", {31'b0, stall_f_o}, 32'h1);
    tick(); @(negedge clk); check("stall_t2", {31'b0, stall_f_o}, 32'h1);
    tick(); @(negedge clk); check("stall_t3", {31'b0, stall_f_o}, 32'h0);
    tick();
    if_req_i = 1'b0;

    // Lone byte store 0x55 -> 0x20; ack carries zero data.
    t = cyc;
    dm_req_i = 1'b1;  dm_we_i = 1'b1;  dm_byte_i = 1'b1;
    dm_addr_i = 32'h20;  dm_wdata_i = 32'h55;
    pushAccess(1'b1, 1'b1, 1'b1, 32'h20, 32'h55, 32'hDEADBEEF, t, 1'b1);
    tick();
    dm_req_i = 1'b0;
    repeat (3) tick();

    // Word load with distinct memory data; IF's rdata must not move.
    t = cyc;
    mem_rdata_i = 32'h12345678;
    dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_byte_i = 1'b0;
    dm_addr_i = 32'h44;  dm_wdata_i = 32'h0;
    pushAccess(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h12345678, t, 1'b1);
    tick();
    dm_req_i = 1'b0;
    repeat (3) tick();
    mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    check("dm_rdata_hold", dm_rdata_o, 32'h12345678);
    check("if_rdata_hold", if_rdata_o, 32'hDEADBEEF);
    check("stall_idle", {31'b0, stall_f_o}, 32'h0);
    tick();
    mem_rdata_i = 32'hDEADBEEF;

    // Clean reset, then both requests held for eight grants: DM x3, IF, DM x3, IF.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t = cyc;
    heldPattern = 8'b0111_0111;  // bit k = 1 -> grant k goes to DM
    if_req_i = 1'b1;  if_addr_i = 32'h200;
    dm_req_i = 1'b1;  dm_we_i = 1'b0;  dm_byte_i = 1'b0;  dm_addr_i = 32'h300;
    for (int k = 0; k < 8; k++) begin
      if (heldPattern[k]) pushAccess(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'hDEADBEEF, t + 4 * k, 1'b1);
      else                pushAccess(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'hDEADBEEF, t + 4 * k, 1'b1);
    end
    repeat (29) tick();
    if_req_i = 1'b0;  dm_req_i = 1'b0;
    repeat (3) tick();
`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    check("perf_conflict", conflict_cnt_o, 32'd8);
    check("perf_starve", starve_cnt_o, 32'd2);
    tick();
`endif

    // Reset lands in WAIT of a fetch: no response, pending fetch re-granted after.
    t = cyc;
    if_req_i = 1'b1;  if_addr_i = 32'h400;
    pushAccess(1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, t, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pushAccess(1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, t + 4, 1'b1);
    tick();
    if_req_i = 1'b0;
    repeat (6) tick();

    check("gnt_queue_drained", gntQ.size(), 32'd0);
    check("mem_queue_drained", memQ.size(), 32'd0);
    check("rsp_queue_drained", rspQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
